// File: rtl/spi_cmd_master.sv
// SPI command master: opcode byte then LENGTH data bytes, LSB-first, mode-0 style SCK; optional nSS gap via SPI_CMD_MASTER_NSS_GAP_EN.
// Latency: SCK half-period CLK_DIV clk; no backpressure, tx_data must be valid the cycle after tx_req and start is dropped while busy.
module spi_cmd_master #(
    parameter int CLK_DIV    = 2,
    parameter int BYTE_WIDTH = 8
`ifdef SPI_CMD_MASTER_NSS_GAP_EN
    ,
    parameter int NSS_GAP_CYCLES = 4
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BYTE_WIDTH-1:0] opcode,
    input  logic [7:0]            length,
    input  logic [BYTE_WIDTH-1:0] tx_data,
    output logic                  tx_req,
    output logic [BYTE_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  spi_nss,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int BCW = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
    localparam logic [15:0]    DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(BYTE_WIDTH - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_SCK_LO   = 3'd2;
    localparam logic [2:0] ST_SCK_HI   = 3'd3;
    localparam logic [2:0] ST_BYTE_END = 3'd4;
    localparam logic [2:0] ST_HOLD     = 3'd5;
`ifdef SPI_CMD_MASTER_NSS_GAP_EN
    localparam logic [2:0] ST_GAP      = 3'd6;
    localparam logic [15:0] GAP_LAST   = 16'(NSS_GAP_CYCLES - 1);
`endif

    logic [2:0]            state_q, state_d;
    logic [15:0]           timer_q, timer_d;
    logic [BCW-1:0]        bit_q, bit_d;
    logic [7:0]            rem_q, rem_d;
    logic [BYTE_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [BYTE_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [BYTE_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  done_q, done_d;
    logic                  load_q, load_d;

    logic                  timer_done;
    logic                  nss_int;
    logic [BYTE_WIDTH-1:0] rx_shift;

    assign timer_done = (timer_q == DIV_LAST);
    assign rx_shift   = {spi_miso, rx_sr_q[BYTE_WIDTH-1:1]};

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_d      = bit_q;
        rem_d      = rem_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        done_d     = 1'b0;
        load_d     = 1'b0;

        // The requested data byte arrives during the first SCK_LO cycle of the next byte.
        if (load_q) begin
            tx_sr_d = tx_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    tx_sr_d = opcode;
                    rem_d   = length;
                    bit_d   = '0;
                    timer_d = '0;
                end
            end
            ST_SETUP: begin
                if (timer_done) begin
                    state_d = ST_SCK_HI;
                    timer_d = '0;
                    rx_sr_d = rx_shift;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_SCK_HI: begin
                if (timer_done) begin
                    timer_d = '0;
                    if (bit_q != BIT_LAST) begin
                        state_d = ST_SCK_LO;
                        bit_d   = bit_q + BCW'(1);
                        tx_sr_d = tx_sr_q >> 1;
                    end else begin
                        state_d = ST_BYTE_END;
                        bit_d   = '0;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_SCK_LO: begin
                if (timer_done) begin
                    state_d = ST_SCK_HI;
                    timer_d = '0;
                    rx_sr_d = rx_shift;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_BYTE_END: begin
                rx_data_d  = rx_sr_q;
                rx_valid_d = 1'b1;
                timer_d    = '0;
                if (rem_q != 8'd0) begin
                    rem_d   = rem_q - 8'd1;
                    load_d  = 1'b1;
                    state_d = ST_SCK_LO;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (timer_done) begin
                    done_d  = 1'b1;
                    timer_d = '0;
`ifdef SPI_CMD_MASTER_NSS_GAP_EN
                    state_d = ST_GAP;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
`ifdef SPI_CMD_MASTER_NSS_GAP_EN
            ST_GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_q      <= '0;
            rem_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_q      <= bit_d;
            rem_q      <= rem_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            load_q     <= load_d;
        end
    end

`ifdef SPI_CMD_MASTER_NSS_GAP_EN
    assign nss_int = (state_q == ST_IDLE) || (state_q == ST_GAP);
`else
    assign nss_int = (state_q == ST_IDLE);
`endif

    // Bypass the shift register while the fresh byte is still only on tx_data.
    assign spi_mosi = nss_int ? 1'b0 : (load_q ? tx_data[0] : tx_sr_q[0]);
    assign spi_nss  = nss_int;
    assign spi_sck  = (state_q == ST_SCK_HI);
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign tx_req   = (state_q == ST_BYTE_END) && (rem_q != 8'd0);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule
